// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the filtered multi-channel edge detector.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RE   = 2'b01,
        EDGE_FE   = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/edge_det_flt_ch.sv
// One channel: synchroniser, debounce filter, edge qualification, sticky pending flag and
// saturating event counter.
module edge_det_flt_ch
    import edge_det_pkg::*;
#(
    parameter int unsigned STAGE     = 2,
    parameter int unsigned FLT_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 dat_i,
    input  logic                 en_i,
    input  edge_mode_e           mode_i,
    input  logic [FLT_WIDTH-1:0] flt_cyc_i,
    input  logic                 clr_i,
    input  logic                 cnt_clr_i,
    output logic                 dat_o,
    output logic                 evt_o,
    output logic                 pend_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [STAGE-1:0]     sync_q;
    logic                 flt_in_q;
    logic                 lvl_q, lvl_d, lvl_prev_q;
    logic [FLT_WIDTH-1:0] fc_q, fc_d;
    logic                 pend_q, pend_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rise, fall, evt;

    // The filter samples the synchroniser output into its own input flop before comparing.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q     <= '0;
            flt_in_q   <= 1'b0;
            fc_q       <= '0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= {sync_q[STAGE-2:0], dat_i};
            flt_in_q   <= sync_q[STAGE-1];
            fc_q       <= fc_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        fc_d  = fc_q;
        lvl_d = lvl_q;
        if (flt_in_q == lvl_q) begin
            fc_d = '0;
        end else if (fc_q >= flt_cyc_i) begin
            lvl_d = flt_in_q;
            fc_d  = '0;
        end else begin
            fc_d = fc_q + FLT_WIDTH'(1);
        end
    end

    assign rise = lvl_q & ~lvl_prev_q;
    assign fall = ~lvl_q & lvl_prev_q;

    always_comb begin
        evt = 1'b0;
        case (mode_i)
            EDGE_OFF:  evt = 1'b0;
            EDGE_RE:   evt = rise;
            EDGE_FE:   evt = fall;
            EDGE_BOTH: evt = rise | fall;
            default:   evt = 1'b0;
        endcase
        evt = evt & en_i;
    end

    // A coincident event beats a clear on both the flag and the counter.
    always_comb begin
        pend_d = evt | (pend_q & ~clr_i);
        cnt_d  = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = evt ? CNT_WIDTH'(1) : '0;
        end else if (evt) begin
            cnt_d = CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_WIDTH));
        end
    end

    assign dat_o  = lvl_q;
    assign evt_o  = evt;
    assign pend_o = pend_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/edge_det_flt.sv
// Multi-channel synchronised, debounced edge detector with sticky flags, counters and an irq.
module edge_det_flt
    import edge_det_pkg::*;
#(
    parameter int unsigned STAGE      = 2,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned FLT_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [DATA_WIDTH-1:0]           dat_i,
    input  logic [DATA_WIDTH-1:0]           en_i,
    input  logic [2*DATA_WIDTH-1:0]         mode_i,
    input  logic [FLT_WIDTH-1:0]            flt_cyc_i,
    input  logic [DATA_WIDTH-1:0]           clr_i,
    input  logic [DATA_WIDTH-1:0]           cnt_clr_i,
    output logic [DATA_WIDTH-1:0]           dat_o,
    output logic [DATA_WIDTH-1:0]           evt_o,
    output logic [DATA_WIDTH-1:0]           pend_o,
    output logic [DATA_WIDTH*CNT_WIDTH-1:0] cnt_o,
    output logic                            irq_o
);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ch
        edge_det_flt_ch #(
            .STAGE     (STAGE),
            .FLT_WIDTH (FLT_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .dat_i     (dat_i[i]),
            .en_i      (en_i[i]),
            .mode_i    (edge_mode_e'(mode_i[2*i +: 2])),
            .flt_cyc_i (flt_cyc_i),
            .clr_i     (clr_i[i]),
            .cnt_clr_i (cnt_clr_i[i]),
            .dat_o     (dat_o[i]),
            .evt_o     (evt_o[i]),
            .pend_o    (pend_o[i]),
            .cnt_o     (cnt_o[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign irq_o = |pend_o;

endmodule

// File: tb/tb_edge_det_flt.sv
// Randomised and directed bench for edge_det_flt with a window-based reference model and a
// queue scoreboard checked every cycle.
module tb_edge_det_flt;

    localparam int unsigned STAGE = 2;
    localparam int unsigned DW    = 4;
    localparam int unsigned FW    = 8;
    localparam int unsigned CW    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     dat, en, clr, cnt_clr;
    logic [2*DW-1:0]   mode;
    logic [FW-1:0]     flt;
    logic [DW-1:0]     dat_o, evt_o, pend_o;
    logic [DW*CW-1:0]  cnt_o;
    logic              irq_o;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [DW-1:0]    dat;
        logic [DW-1:0]    evt;
        logic [DW-1:0]    pend;
        logic [DW*CW-1:0] cnt;
        logic             irq;
    } exp_t;

    exp_t exp_q[$];

    edge_det_flt #(
        .STAGE      (STAGE),
        .DATA_WIDTH (DW),
        .FLT_WIDTH  (FW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .dat_i     (dat),
        .en_i      (en),
        .mode_i    (mode),
        .flt_cyc_i (flt),
        .clr_i     (clr),
        .cnt_clr_i (cnt_clr),
        .dat_o     (dat_o),
        .evt_o     (evt_o),
        .pend_o    (pend_o),
        .cnt_o     (cnt_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_evt(input int ch, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!evt_o[ch] && n < limit);
    endtask

    // Reference model: a channel's level flips once the last flt+1 filter-input samples all
    // disagree with it; the filter input is the raw sample taken STAGE+1 edges earlier.
    initial begin
        logic [DW-1:0] samp_q[$];
        logic [DW-1:0] xh_q[$];
        logic [DW-1:0] lvl_m, prev_m, pend_m, evt_m, x;
        logic [CW-1:0] cnt_m[DW];
        logic [1:0]    m;
        logic          ok, v;
        int            idx;
        exp_t          e;
        lvl_m = '0; prev_m = '0; pend_m = '0; evt_m = '0;
        for (int c = 0; c < DW; c++) cnt_m[c] = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                samp_q.delete();
                xh_q.delete();
                lvl_m = '0; prev_m = '0; pend_m = '0;
                for (int c = 0; c < DW; c++) cnt_m[c] = '0;
            end else begin
                for (int c = 0; c < DW; c++) begin
                    pend_m[c] = evt_m[c] | (pend_m[c] & ~clr[c]);
                    if (cnt_clr[c]) cnt_m[c] = evt_m[c] ? CW'(1) : '0;
                    else if (evt_m[c] && cnt_m[c] != {CW{1'b1}}) cnt_m[c] = cnt_m[c] + 1'b1;
                end
                samp_q.push_back(dat);
                x = (samp_q.size() > STAGE + 1) ? samp_q[samp_q.size() - 1 - (STAGE + 1)] : '0;
                xh_q.push_back(x);
                if (samp_q.size() > 64) void'(samp_q.pop_front());
                if (xh_q.size() > 64) void'(xh_q.pop_front());
                prev_m = lvl_m;
                for (int c = 0; c < DW; c++) begin
                    ok = 1'b1;
                    for (int j = 0; j <= int'(flt); j++) begin
                        idx = xh_q.size() - 1 - j;
                        v   = (idx >= 0) ? xh_q[idx][c] : 1'b0;
                        if (v == prev_m[c]) ok = 1'b0;
                    end
                    if (ok) lvl_m[c] = ~prev_m[c];
                end
            end
            #2;
            for (int c = 0; c < DW; c++) begin
                m = mode[2*c +: 2];
                evt_m[c] = en[c] && (((m == 2'b01 || m == 2'b11) && lvl_m[c] && !prev_m[c]) ||
                                     ((m == 2'b10 || m == 2'b11) && !lvl_m[c] && prev_m[c]));
            end
            e.dat  = lvl_m;
            e.evt  = evt_m;
            e.pend = pend_m;
            for (int c = 0; c < DW; c++) e.cnt[c*CW +: CW] = cnt_m[c];
            e.irq  = |pend_m;
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dat_o", 32'(dat_o), 32'(e.dat));
                check("evt_o", 32'(evt_o), 32'(e.evt));
                check("pend_o", 32'(pend_o), 32'(e.pend));
                check("cnt_o", 32'(cnt_o), 32'(e.cnt));
                check("irq_o", 32'(irq_o), 32'(e.irq));
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; dat = '0; en = '0; mode = '0; flt = 8'd3; clr = '0; cnt_clr = '0;
        repeat (3) tick();
        check("reset_dat_o", 32'(dat_o), 32'd0);
        check("reset_cnt_o", 32'(cnt_o), 32'd0);
        rst_n = 1'b1;
        en = '1;
        mode = 8'b01010101;
        repeat (8) tick();

        // Latency: first sampling edge is the tick after the change, evt seven ticks later.
        dat[0] = 1'b1;
        wait_evt(0, 20, n);
        check("rise_latency", 32'(n), 32'd7);
        check("rise_dat_o", 32'(dat_o[0]), 32'd1);

        // Clear coincident with the event loses to the set; a lone clear then drops it.
        clr = 4'b0001;
        tick();
        check("pend_set_wins", 32'(pend_o[0]), 32'd1);
        clr = 4'b1111;
        tick();
        check("pend_cleared", 32'(pend_o[0]), 32'd0);
        check("irq_cleared", 32'(irq_o), 32'd0);
        clr = '0;

        // Glitch of flt cycles rejected, flt+1 accepted, both edges counted in BOTH mode.
        mode[1:0] = 2'b11;
        dat[0] = 1'b0;
        repeat (10) tick();
        cnt_clr = 4'b0001;
        tick();
        cnt_clr = '0;
        dat[0] = 1'b1;
        repeat (3) tick();
        dat[0] = 1'b0;
        repeat (12) tick();
        check("glitch_rejected", 32'(cnt_o[CW-1:0]), 32'd0);
        dat[0] = 1'b1;
        repeat (4) tick();
        dat[0] = 1'b0;
        repeat (12) tick();
        check("pulse_accepted", 32'(cnt_o[CW-1:0]), 32'd2);

        // Counter saturation, then a clear coincident with an event.
        mode[3:2] = 2'b11;
        flt = 8'd0;
        for (int t = 0; t < 20; t++) begin
            dat[1] = ~dat[1];
            repeat (3) tick();
        end
        repeat (6) tick();
        check("cnt_saturate", 32'(cnt_o[CW +: CW]), 32'd15);
        dat[1] = ~dat[1];
        wait_evt(1, 20, n);
        check("evt_seen_ch1", 32'(evt_o[1]), 32'd1);
        cnt_clr = 4'b0010;
        tick();
        cnt_clr = '0;
        check("cnt_clr_with_evt", 32'(cnt_o[CW +: CW]), 32'd1);

        // Reset in the middle of a filter count, then full re-qualification.
        flt = 8'd3;
        repeat (4) tick();
        dat[2] = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check("midflt_reset_dat", 32'(dat_o), 32'd0);
        check("midflt_reset_cnt", 32'(cnt_o), 32'd0);
        rst_n = 1'b1;
        wait_evt(2, 20, n);
        check("post_reset_latency", 32'(n), 32'd7);

        // Random traffic: levels, modes, enables, thresholds, clears and occasional resets.
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 5) == 0) dat[$urandom_range(0, DW - 1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                en   = DW'($urandom);
                mode = (2*DW)'($urandom);
            end
            if ($urandom_range(0, 59) == 0) flt = FW'($urandom_range(0, 5));
            for (int c = 0; c < DW; c++) begin
                clr[c]     = ($urandom_range(0, 7) == 0);
                cnt_clr[c] = ($urandom_range(0, 29) == 0);
            end
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1; clr = '0; cnt_clr = '0;
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
